// File: rtl/div.sv
// Sequential signed 32-bit divider for the Hi/Lo unit.
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle,
// followed by a sign fix-up that writes quotient to Lo and remainder to Hi.
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        div_end,
  output logic        div_zero
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [W-1:0]     dvd, dvd_n;
  logic [W-1:0]     dsr, dsr_n;
  logic [W:0]       rem, rem_n;
  logic             sign_q, sign_q_n;
  logic             sign_r, sign_r_n;
  logic [W-1:0]     hi_n, lo_n;
  logic             div_end_n, div_zero_n;

  // Single-iteration datapath: shift the next dividend bit into the remainder.
  logic [W:0]       shifted_c;
  logic             fits_c;
  logic [W-1:0]     abs_a_c, abs_b_c;

  // Magnitudes use plain 32-bit negate, so 0x80000000 maps to itself.
  always_comb begin
    abs_a_c   = a[W-1] ? W'(~a + W'(1)) : a;
    abs_b_c   = b[W-1] ? W'(~b + W'(1)) : b;
    shifted_c = {rem[W-1:0], dvd[W-1]};
    fits_c    = (shifted_c >= {1'b0, dsr});
  end

  // State register and all datapath/output registers; reset has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      div_end  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dvd      <= dvd_n;
      dsr      <= dsr_n;
      rem      <= rem_n;
      sign_q   <= sign_q_n;
      sign_r   <= sign_r_n;
      Hi       <= hi_n;
      Lo       <= lo_n;
      div_end  <= div_end_n;
      div_zero <= div_zero_n;
    end
  end

  // Next-state and next-output logic; a start strobe overrides any state.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dvd_n      = dvd;
    dsr_n      = dsr;
    rem_n      = rem;
    sign_q_n   = sign_q;
    sign_r_n   = sign_r;
    hi_n       = Hi;
    lo_n       = Lo;
    div_end_n  = 1'b0;
    div_zero_n = 1'b0;

    if (div_ctrl) begin
      dvd_n    = abs_a_c;
      dsr_n    = abs_b_c;
      rem_n    = '0;
      sign_q_n = a[W-1] ^ b[W-1];
      sign_r_n = a[W-1];
      cnt_n    = CNT_W'(W - 1);
      state_n  = (b == '0) ? S_ZERO : S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (fits_c) begin
            rem_n = shifted_c - {1'b0, dsr};
            dvd_n = {dvd[W-2:0], 1'b1};
          end else begin
            rem_n = shifted_c;
            dvd_n = {dvd[W-2:0], 1'b0};
          end
          if (cnt == '0) begin
            state_n = S_FIX;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          lo_n      = sign_q ? W'(~dvd + W'(1)) : dvd;
          hi_n      = sign_r ? W'(~rem[W-1:0] + W'(1)) : rem[W-1:0];
          div_end_n = 1'b1;
          state_n   = S_IDLE;
        end
        S_ZERO: begin
          div_end_n  = 1'b1;
          div_zero_n = 1'b1;
          state_n    = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the sequential signed divider.
module tb_div;

  logic        clk;
  logic        reset;
  logic        div_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        div_end;
  logic        div_zero;

  int errors;
  int checks;

  div dut (
    .clk      (clk),
    .reset    (reset),
    .div_ctrl (div_ctrl),
    .a        (a),
    .b        (b),
    .Hi       (Hi),
    .Lo       (Lo),
    .div_end  (div_end),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start strobe onto the next rising edge (E0), then scramble operands.
  task automatic start(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    div_ctrl = 1'b1;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    div_ctrl = 1'b0;
    a        = $urandom;
    b        = $urandom;
    chk("end_low_after_start", 32'(div_end), 32'd0);
  endtask

  // Full operation: no div_end during E1..E32, result and pulse after E33.
  task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int early;
    early = 0;
    start(av, bv);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      if (div_end !== 1'b0) early++;
    end
    chk({tag, "_early_end"}, 32'(early), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_end"}, 32'(div_end), 32'd1);
    chk({tag, "_zero"}, 32'(div_zero), 32'd0);
    chk({tag, "_lo"}, Lo, exp_lo);
    chk({tag, "_hi"}, Hi, exp_hi);
  endtask

  task automatic end_drops(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_end_drop"}, 32'(div_end), 32'd0);
  endtask

  initial begin
    int seen;
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    div_ctrl = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_end", 32'(div_end), 32'd0);
    chk("rst_zero", 32'(div_zero), 32'd0);

    // Reset together with a start: reset wins.
    @(negedge clk);
    div_ctrl = 1'b1;
    a        = 32'd7;
    b        = 32'd2;
    @(posedge clk);
    #1;
    div_ctrl = 1'b0;
    reset    = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (div_end !== 1'b0) seen++;
    end
    chk("rst_start_ignored", 32'(seen), 32'd0);

    // Sign combinations and boundary cases.
    do_div("p7_p2", 32'd7, 32'd2, 32'h00000003, 32'h00000001);
    end_drops("p7_p2");
    do_div("n7_p2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    do_div("p7_n2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    do_div("n7_n2", 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
    do_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    do_div("small", 32'd5, 32'd9, 32'h00000000, 32'h00000005);
    end_drops("small");

    // Divide by zero leaves the previous result in place.
    do_div("pre", 32'd100, 32'd7, 32'd14, 32'd2);
    end_drops("pre");
    start(32'd3, 32'd0);
    @(posedge clk);
    #1;
    chk("dz_zero", 32'(div_zero), 32'd1);
    chk("dz_end", 32'(div_end), 32'd1);
    chk("dz_hi", Hi, 32'd2);
    chk("dz_lo", Lo, 32'd14);
    @(posedge clk);
    #1;
    chk("dz_zero_drop", 32'(div_zero), 32'd0);
    chk("dz_end_drop", 32'(div_end), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (div_end !== 1'b0 || div_zero !== 1'b0) seen++;
    end
    chk("dz_no_late_end", 32'(seen), 32'd0);
    chk("dz_hi_hold", Hi, 32'd2);
    chk("dz_lo_hold", Lo, 32'd14);

    // Reset in the middle of an operation.
    start(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_hi", Hi, 32'd0);
    chk("mid_rst_lo", Lo, 32'd0);
    seen = 0;
    for (int i = 11; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (div_end !== 1'b0) seen++;
    end
    chk("mid_rst_no_end", 32'(seen), 32'd0);

    // Restart while busy: only the second operation completes.
    start(32'd100, 32'd7);
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (div_end !== 1'b0) seen++;
    end
    chk("abort_no_end", 32'(seen), 32'd0);
    do_div("restart", 32'd9, 32'd4, 32'd2, 32'd1);
    end_drops("restart");

    // Back-to-back: second start on the done-pulse edge.
    do_div("b2b_1", 32'd20, 32'd6, 32'd3, 32'd2);
    do_div("b2b_2", 32'd9, 32'd3, 32'd3, 32'd0);
    end_drops("b2b_2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
